data_modulate_7x7_ctrl: RTL
===========================

DATA_MODULATE_7X7_CTRL -- requirements
Module: data_modulate_7x7_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 7: frame height in pixels (>=4).
REQ-002 SHALL have parameter COLS, default 7: frame width in pixels (>=4).
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port frame_start, input, 1: one-cycle pulse that starts a frame; honoured only in IDLE.
REQ-006 SHALL have port in_valid, input, 1: a 7-row pixel column is present on the line-buffer outputs.
REQ-007 SHALL have port in_ready, output, 1: the column is consumed this cycle when in_valid && in_ready.
REQ-008 SHALL have port shift_en, output, 1: shift enable to the 7x7 window register (datapath start).
REQ-009 SHALL have port win_valid, output, 1: the 7x7 window is complete (datapath done_o).
REQ-010 SHALL have port out_ready, input, 1: downstream accepts the window when win_valid && out_ready.
REQ-011 SHALL have ports win_row and win_col, output, 10 each: centre coordinate of the current window.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have port frame_done, output, 1: one-cycle pulse when the last window of the frame is accepted.

Function
REQ-014 SHALL implement the states IDLE, LOAD, FLUSH and DRAIN.
REQ-015 SHALL keep shift_cnt (0..COLS+2) and row_cnt (0..ROWS-1) as 10-bit registers.
REQ-016 SHALL define adv = !win_valid || out_ready; no shift occurs while a window is pending and unaccepted.
REQ-017 SHALL set in_ready = (state==LOAD) && adv.
REQ-018 SHALL set shift_en = (in_valid && in_ready) in LOAD, = adv in FLUSH, and 0 in IDLE and DRAIN.
REQ-019 SHALL move IDLE->LOAD on frame_start, clearing shift_cnt, row_cnt, win_row and win_col.
REQ-020 SHALL increment shift_cnt on each shift_en; LOAD->FLUSH on the shift with shift_cnt==COLS-1.
REQ-021 SHALL, on the FLUSH shift with shift_cnt==COLS+2:
- if row_cnt<ROWS-1: go to LOAD, shift_cnt=0, row_cnt+1;
- else: go to DRAIN.
REQ-022 SHALL register win_valid=1 on a shift with shift_cnt>=3 (pre-increment); otherwise clear it on win_valid && out_ready.
REQ-023 SHALL latency: first window of a row 1 cycle after the 4th shift; exactly COLS windows and COLS+3 shifts per row.
REQ-024 SHALL advance win_col (wrapping at COLS-1) on each accepted window; on the wrap, advance win_row.
REQ-025 SHALL in DRAIN go to IDLE and pulse frame_done in the cycle after the final window is accepted.
REQ-026 SHALL ignore frame_start while busy.
REQ-027 SHALL, when out_ready is low, hold win_valid, win_row and win_col stable and keep shift_en low.
REQ-028 SHALL allow acceptance and a new shift in the same cycle (back-to-back windows at full rate).

Reset
REQ-029 SHALL in rst:
- state = IDLE;
- in_ready, shift_en, win_valid, busy, frame_done = 0;
- win_row, win_col, shift_cnt, row_cnt = 0.
REQ-030 SHALL let rst asserted mid-frame abort the frame with no frame_done pulse.

Structure
REQ-031 SHALL place the state encoding, HALF=3 and WIN=7 in the shared package data_modulate_pkg.
REQ-032 SHALL be a single module with no sub-module; counters are inline registers, not plus_1 instances.

Verification
REQ-033 SHALL cover, with ROWS=COLS=7, in_valid=1, out_ready=1 and frame_start at cycle 0:
- first win_valid at cycle 5;
- 49 windows, 49 input handshakes, 70 shift_en cycles;
- exactly one frame_done.
REQ-034 SHALL cover out_ready=0 for 5 cycles on window (2,3): win_valid, win_row=2 and win_col=3 held; shift_en=0; no lost windows.
REQ-035 SHALL cover in_valid toggling every other cycle: identical window sequence (row-major 0..6), 49 windows.
REQ-036 SHALL cover frame_start pulsed while busy: ignored; window count stays 49.
REQ-037 SHALL cover rst at cycle 30: next cycle IDLE with all outputs 0, no frame_done; a new frame then runs fully.
REQ-038 SHALL cover ROWS=4, COLS=5: 20 windows; 8 shifts per row; LOAD->FLUSH after 5 shifts each row.

Source files
------------

// File: rtl/data_modulate_pkg.sv
// Shared definitions for the 7x7 window modulation controller: FSM encoding and window geometry.
package data_modulate_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int HALF  = 3;
    localparam int WIN   = 7;
    localparam int CNT_W = 10;

endpackage

// File: rtl/data_modulate_7x7_ctrl.sv
// Sequences line-buffer columns into a 7x7 window register; first window 1 cycle after the 4th shift.
// A pending, unaccepted window (out_ready low) stalls all shifting and input consumption.
module data_modulate_7x7_ctrl
    import data_modulate_pkg::*;
#(
    parameter int ROWS = 7,
    parameter int COLS = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             shift_en,
    output logic             win_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] win_row,
    output logic [CNT_W-1:0] win_col,
    output logic             busy,
    output logic             frame_done
);

    localparam logic [CNT_W-1:0] LAST_LOAD  = CNT_W'(COLS - 1);
    localparam logic [CNT_W-1:0] LAST_FLUSH = CNT_W'(COLS + HALF - 1);
    localparam logic [CNT_W-1:0] LAST_ROW   = CNT_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] LAST_COL   = CNT_W'(COLS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] shift_cnt_q, shift_cnt_d;
    logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
    logic [CNT_W-1:0] win_row_q, win_row_d;
    logic [CNT_W-1:0] win_col_q, win_col_d;
    logic             win_valid_q, win_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             adv;
    logic             accept;

    assign adv    = !win_valid_q || out_ready;
    assign accept = win_valid_q && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shift_cnt_q  <= '0;
            row_cnt_q    <= '0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_cnt_q  <= shift_cnt_d;
            row_cnt_q    <= row_cnt_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_cnt_d  = shift_cnt_q;
        row_cnt_d    = row_cnt_q;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        win_valid_d  = win_valid_q;
        frame_done_d = 1'b0;

        // The window register holds a full 7x7 once the first HALF+1 columns are in.
        if (shift_en && (shift_cnt_q >= CNT_W'(HALF))) begin
            win_valid_d = 1'b1;
        end else if (accept) begin
            win_valid_d = 1'b0;
        end

        if (accept) begin
            if (win_col_q == LAST_COL) begin
                win_col_d = '0;
                win_row_d = (win_row_q == LAST_ROW) ? '0 : win_row_q + 1'b1;
            end else begin
                win_col_d = win_col_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d     = ST_LOAD;
                    shift_cnt_d = '0;
                    row_cnt_d   = '0;
                    win_row_d   = '0;
                    win_col_d   = '0;
                end
            end
            ST_LOAD: begin
                if (shift_en) begin
                    shift_cnt_d = shift_cnt_q + 1'b1;
                    if (shift_cnt_q == LAST_LOAD) state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Zero-padding shifts push the right image edge through the window centre.
                if (shift_en) begin
                    if (shift_cnt_q == LAST_FLUSH) begin
                        if (row_cnt_q < LAST_ROW) begin
                            state_d     = ST_LOAD;
                            shift_cnt_d = '0;
                            row_cnt_d   = row_cnt_q + 1'b1;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        shift_cnt_d = shift_cnt_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (accept) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        shift_en = 1'b0;
        busy     = (state_q != ST_IDLE);
        case (state_q)
            ST_LOAD: begin
                in_ready = adv;
                shift_en = in_valid && adv;
            end
            ST_FLUSH: shift_en = adv;
            default: ;
        endcase
    end

    assign win_valid  = win_valid_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign frame_done = frame_done_q;

endmodule
